// File: rtl/uart_pkg.sv
// Shared UART definitions: sampler state encoding and the bit-window helper
// that maps a prescale value onto the mid-bit sample slots.
package uart_pkg;

    localparam int MAX_SAMPLES = 7;
    // Window arithmetic width: prescale up to 16 bits plus a sign bit and headroom.
    // Results are identical to evaluating in PRESCALE_W+1 bits because every
    // intermediate value fits comfortably in that narrower signed range.
    localparam int WIN_W = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } samp_state_e;

    typedef struct packed {
        logic signed [WIN_W-1:0] center;
        logic signed [WIN_W-1:0] first;
        logic signed [WIN_W-1:0] last;
        logic                    bad;    // window falls outside 0..prescale-1
    } slot_win_t;

    // Centre of the bit is (prescale/2)-1; the window spans +/- half_span
    // around it. A negative first slot or a last slot beyond the bit end
    // means the prescale cannot host that many samples.
    function automatic slot_win_t calc_slot_window(input logic [15:0] prescale,
                                                   input logic [2:0]  half_span);
        slot_win_t w;
        logic signed [WIN_W-1:0] p_s;
        logic signed [WIN_W-1:0] k_s;
        p_s      = $signed({2'b00, prescale});
        k_s      = $signed({15'd0, half_span});
        w.center = $signed({3'b000, prescale[15:1]}) - 18'sd1;
        w.first  = w.center - k_s;
        w.last   = w.center + k_s;
        w.bad    = (w.first < 0) || (w.last > (p_s - 18'sd1));
        return w;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Reset-to-idle (1) multi-flop synchronizer for the serial line.
// STAGES=0 degenerates to a plain wire.
module uart_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q_o = d_i;
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;

            // Shift the line through the flop chain; reset fills it with idle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign q_o = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/uart_rx_vote_sampler.sv
// UART RX mid-bit sampler: captures NUM_SAMPLES line samples centred on the
// middle of each bit, majority-votes them and flags non-unanimous/missed
// samples. NUM_SAMPLES must be odd and at most MAX_SAMPLES; PRESCALE_W <= 16.
module uart_rx_vote_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_count,
    input  logic                  s_data,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int K     = (NUM_SAMPLES - 1) / 2;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    logic                   s_sync;
    slot_win_t              slot_win;
    logic [WIN_W-1:0]       cnt_w;
    logic [NUM_SAMPLES-1:0] slot_hit;
    logic                   at_last;
    logic                   cnt_zero;

    logic                   cfg_err_d;
    logic                   cfg_err_q;

    samp_state_e            state_q;
    logic [NUM_SAMPLES-1:0] samp_q;
    logic [NUM_SAMPLES-1:0] mask_q;
    logic                   sampled_bit_q;
    logic                   sample_valid_q;
    logic                   noise_err_q;

    logic [NUM_SAMPLES-1:0] vote_bits;
    logic [NUM_SAMPLES-1:0] vote_mask;
    logic [CNT_W-1:0]       ones;
    logic                   vote_bit;
    logic                   vote_noise;

    uart_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (s_data),
        .q_o (s_sync)
    );

    assign slot_win  = calc_slot_window(16'(prescale), 3'(K));
    assign cfg_err_d = slot_win.bad;
    assign cnt_w     = WIN_W'(edge_count);
    assign at_last   = (cnt_w == slot_win.last);
    assign cnt_zero  = (edge_count == '0);

    // The centre itself is only needed by the TX bit timer.
    logic unused_center;
    assign unused_center = ^slot_win.center;

    // Slot i sits at edge_count == first + i.
    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            slot_hit[i] = (cnt_w == (slot_win.first + WIN_W'(i)));
        end
    end

    // Vote over the stored samples plus the final slot being taken this cycle;
    // missed slots count as zero and always mark the bit noisy.
    always_comb begin
        vote_bits                = samp_q;
        vote_mask                = mask_q;
        vote_bits[NUM_SAMPLES-1] = s_sync;
        vote_mask[NUM_SAMPLES-1] = 1'b1;
        ones                     = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            ones = ones + CNT_W'(vote_bits[i] & vote_mask[i]);
        end
        vote_bit   = (ones >= CNT_W'(K + 1));
        vote_noise = !(&vote_mask) ||
                     ((ones != '0) && (ones != CNT_W'(NUM_SAMPLES)));
    end

    // Registered configuration check; valid one cycle after prescale moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    // Sampling FSM with registered vote outputs; dropping enable always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            samp_q         <= '0;
            mask_q         <= '0;
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
            noise_err_q    <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                samp_q  <= '0;
                mask_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        samp_q <= '0;
                        mask_q <= '0;
                        if (!cfg_err_q) begin
                            state_q <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (cfg_err_q) begin
                            state_q <= IDLE;
                            samp_q  <= '0;
                            mask_q  <= '0;
                        end else begin
                            for (int i = 0; i < NUM_SAMPLES; i++) begin
                                if (slot_hit[i] && !mask_q[i]) begin
                                    samp_q[i] <= s_sync;
                                    mask_q[i] <= 1'b1;
                                end
                            end
                            if (at_last) begin
                                sampled_bit_q  <= vote_bit;
                                noise_err_q    <= vote_noise;
                                sample_valid_q <= 1'b1;
                                state_q        <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        // Hold samples until the next bit starts, so a counter
                        // stalled on the last slot cannot vote twice.
                        if (cnt_zero && !cfg_err_q) begin
                            state_q <= COLLECT;
                            samp_q  <= '0;
                            mask_q  <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        samp_q  <= '0;
                        mask_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign noise_err    = noise_err_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Bench for uart_rx_vote_sampler: three instances (3 samples/no sync,
// 5 samples/no sync, 3 samples/2-stage sync) share the line and counter,
// each with its own enable, against a per-bit reference model.
module tb_uart_rx_vote_sampler;
    import uart_pkg::*;

    localparam int PW    = 6;
    localparam int ND    = 3;
    localparam int DEPTH = 8192;

    logic          clk;
    logic          rst;
    logic [ND-1:0] en;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_count;
    logic          s_data;
    logic [ND-1:0] sb, sv, ne, ce;

    uart_rx_vote_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3), .SYNC_STAGES(0)) dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .prescale(prescale), .edge_count(edge_count),
        .s_data(s_data), .sampled_bit(sb[0]), .sample_valid(sv[0]), .noise_err(ne[0]), .cfg_err(ce[0]));
    uart_rx_vote_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(5), .SYNC_STAGES(0)) dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .prescale(prescale), .edge_count(edge_count),
        .s_data(s_data), .sampled_bit(sb[1]), .sample_valid(sv[1]), .noise_err(ne[1]), .cfg_err(ce[1]));
    uart_rx_vote_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .enable(en[2]), .prescale(prescale), .edge_count(edge_count),
        .s_data(s_data), .sampled_bit(sb[2]), .sample_valid(sv[2]), .noise_err(ne[2]), .cfg_err(ce[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   t        = 0;      // index of the cycle being driven
    int   pres     = 8;
    logic hist [DEPTH];      // line value driven in each cycle
    logic rsth [DEPTH];      // reset driven in each cycle
    int   pc   [ND];         // observed pulses per instance

    // Reference model state, per instance
    logic m_open  [ND];
    int   m_cap   [ND][MAX_SAMPLES];
    logic m_bit   [ND];
    logic m_noise [ND];
    logic m_cfg   [ND];
    logic m_valid [ND];

    function automatic int ns_of(int k);  return (k == 1) ? 5 : 3; endfunction
    function automatic int dly_of(int k); return (k == 2) ? 2 : 0; endfunction
    function automatic int k_of(int k);   return (ns_of(k) - 1) / 2; endfunction
    function automatic int first_of(int k, int p); return p / 2 - 1 - k_of(k); endfunction
    function automatic int last_of(int k, int p);  return p / 2 - 1 + k_of(k); endfunction
    function automatic logic bad_of(int k, int p);
        return (first_of(k, p) < 0) || (last_of(k, p) > p - 1);
    endfunction

    // Line as seen after a d-cycle delay; a reset inside the delay window
    // flushes it to idle.
    function automatic logic line_at(int d, int tc);
        if (d == 0) return hist[tc];
        for (int j = tc - d; j < tc; j++) begin
            if (j < 0) return 1'b1;
            if (rsth[j]) return 1'b1;
        end
        return hist[tc - d];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, t);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic [ND-1:0] e, input int cnt, input logic d);
        rst = r; en = e; edge_count = PW'(cnt); s_data = d; prescale = PW'(pres);
        hist[t] = d; rsth[t] = r;
        for (int k = 0; k < ND; k++) begin
            logic ss;
            int   fs, ls, ones;
            logic miss;
            ss = line_at(dly_of(k), t);
            fs = first_of(k, pres);
            ls = last_of(k, pres);
            m_valid[k] = 1'b0;
            if (r) begin
                m_open[k] = 1'b0; m_bit[k] = 1'b1; m_noise[k] = 1'b0; m_cfg[k] = 1'b0;
            end else begin
                if (!e[k]) begin
                    m_open[k] = 1'b0;
                end else if (!m_open[k]) begin
                    if (cnt == 0 && !m_cfg[k]) begin
                        m_open[k] = 1'b1;
                        for (int i = 0; i < MAX_SAMPLES; i++) m_cap[k][i] = -1;
                    end
                end else begin
                    if (cnt >= fs && cnt <= ls && m_cap[k][cnt - fs] < 0)
                        m_cap[k][cnt - fs] = ss ? 1 : 0;
                    if (cnt == ls) begin
                        ones = 0; miss = 1'b0;
                        for (int i = 0; i < ns_of(k); i++) begin
                            if (m_cap[k][i] < 0) miss = 1'b1;
                            else ones += m_cap[k][i];
                        end
                        m_bit[k]   = (ones >= k_of(k) + 1);
                        m_noise[k] = miss || (ones != 0 && ones != ns_of(k));
                        m_valid[k] = 1'b1;
                        m_open[k]  = 1'b0;
                    end
                end
                m_cfg[k] = bad_of(k, pres);
            end
        end
        @(posedge clk);
        #1;
        t++;
        for (int k = 0; k < ND; k++) begin
            if (sv[k] === 1'b1) pc[k]++;
            chk($sformatf("valid%0d", k), 8'(sv[k]), 8'(m_valid[k]));
            chk($sformatf("bit%0d", k),   8'(sb[k]), 8'(m_bit[k]));
            chk($sformatf("cfg%0d", k),   8'(ce[k]), 8'(m_cfg[k]));
            if (m_valid[k]) chk($sformatf("noise%0d", k), 8'(ne[k]), 8'(m_noise[k]));
        end
        chk("s_sync2", 8'(dut2.s_sync), 8'(line_at(2, t)));
    endtask

    task automatic idle(input int p, input int n);
        pres = p;
        repeat (n) step(1'b0, '0, 0, 1'b1);
    endtask

    task automatic run_bit(input int p, input logic [ND-1:0] e, input logic [63:0] line);
        pres = p;
        for (int c = 0; c < p; c++) step(1'b0, e, c, line[c]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, nb;
        logic [63:0] ln;
        for (int k = 0; k < ND; k++) pc[k] = 0;
        rst = 1'b1; en = '0; edge_count = '0; s_data = 1'b1; prescale = PW'(8);

        // Reset values
        step(1'b1, '0, 0, 1'b1);
        step(1'b1, '0, 0, 1'b1);
        chk("rst_state0", 8'(dut0.state_q), 8'(IDLE));
        chk("rst_noise0", 8'(ne[0]), 8'h0);
        chk("rst_noise2", 8'(ne[2]), 8'h0);

        // Basic vote: all zeros, then 1,0,1 majority on the 3-sample slots
        idle(8, 1);
        p0 = pc[0];
        run_bit(8, 3'b111, 64'h0);
        chk("basic_pulses0", 8'(pc[0] - p0), 8'd1);
        run_bit(8, 3'b111, 64'h14);
        chk("noise_bit0",   8'(sb[0]), 8'h1);
        chk("noise_flag0",  8'(ne[0]), 8'h1);
        chk("noise_pulses0", 8'(pc[0] - p0), 8'd2);

        // Five-sample vote: 0,1,1,0,1 on counts 5..9
        idle(16, 1);
        run_bit(16, 3'b010, 64'h2C0);
        chk("wide_bit1",   8'(sb[1]), 8'h1);
        chk("wide_noise1", 8'(ne[1]), 8'h1);

        // Stall on the last slot, then wrap into the next bit
        idle(8, 1);
        p0 = pc[0];
        for (int c = 0; c < 4; c++) step(1'b0, 3'b101, c, 1'($urandom));
        repeat (5) step(1'b0, 3'b101, 4, 1'($urandom));
        chk("stall_pulses0", 8'(pc[0] - p0), 8'd1);
        run_bit(8, 3'b101, {$urandom, $urandom});
        chk("rearm_pulses0", 8'(pc[0] - p0), 8'd2);

        // Enable drops at count 3: no vote, bit held
        idle(8, 1);
        p0 = pc[0];
        for (int c = 0; c < 3; c++) step(1'b0, 3'b001, c, 1'($urandom));
        for (int c = 3; c < 8; c++) step(1'b0, 3'b000, c, 1'($urandom));
        chk("disable_pulses0", 8'(pc[0] - p0), 8'd0);

        // Counter restarts before reaching last: vote only at the next last
        idle(8, 1);
        p0 = pc[0];
        for (int c = 0; c < 4; c++) step(1'b0, 3'b001, c, 1'($urandom));
        run_bit(8, 3'b001, {$urandom, $urandom});
        chk("jump_pulses0", 8'(pc[0] - p0), 8'd1);

        // Random prescales and line data
        for (int it = 0; it < 20; it++) begin
            p0 = $urandom_range(8, 63);
            idle(p0, 1);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                ln = {$urandom, $urandom};
                run_bit(p0, 3'b111, ln);
            end
        end

        // Illegal prescale for the 5-sample instance, then for 3 samples
        idle(8, 1);
        chk("cfg_pre1", 8'(ce[1]), 8'h0);
        idle(4, 1);
        chk("cfg_set1", 8'(ce[1]), 8'h1);
        chk("cfg_ok0",  8'(ce[0]), 8'h0);
        p0 = pc[1];
        repeat (3) run_bit(4, 3'b010, {$urandom, $urandom});
        chk("cfg_pulses1", 8'(pc[1] - p0), 8'd0);
        idle(2, 1);
        chk("cfg_set0", 8'(ce[0]), 8'h1);
        idle(8, 1);

        // Reset mid-bit at count 4
        for (int c = 0; c < 4; c++) step(1'b0, 3'b111, c, 1'b0);
        step(1'b1, 3'b111, 4, 1'b0);
        chk("midrst_state0", 8'(dut0.state_q), 8'(IDLE));
        chk("midrst_state1", 8'(dut1.state_q), 8'(IDLE));
        chk("midrst_state2", 8'(dut2.state_q), 8'(IDLE));
        chk("midrst_bit0",   8'(sb[0]), 8'h1);
        chk("midrst_valid0", 8'(sv[0]), 8'h0);

        // Synchronizer latency: line falls at a known clock
        idle(8, 3);
        step(1'b0, '0, 0, 1'b0);
        chk("sync_hold2", 8'(dut2.s_sync), 8'h1);
        step(1'b0, '0, 0, 1'b0);
        chk("sync_follow2", 8'(dut2.s_sync), 8'h0);
        run_bit(8, 3'b100, 64'h0F);
        run_bit(8, 3'b100, {$urandom, $urandom});
        idle(8, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
